lstm_bp_dgate_ctrl: RTL and testbench

//   Backprop-phase controller for one LSTM layer: producer side of the delta-gate RAMs (dA/dI/dF/dO).

---
 rtl/lstm_bp_dgate_ctrl_if.sv | 32 +++
 rtl/lstm_bp_dgate_ctrl.sv | 158 +++++++++++++++
 tb/tb_lstm_bp_dgate_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lstm_bp_dgate_ctrl_if.sv
// Handshake and RAM-address bundle between the LSTM backprop delta-gate
// controller and its surroundings.
//   start/stall        : sequencing inputs to the controller
//   busy/done          : sweep status towards the update-phase controller
//   rd_en/rd_addr      : read port for the dOut/dState/activation RAMs
//   wr_dgate/wr_addr   : shared write port for the dA/dI/dF/dO RAMs
//   t_idx/first_t      : timestep information for the datapath
// The master modport is the controller's view; slave is the environment's view.
interface lstm_bp_dgate_ctrl_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  start;
  logic                  stall;
  logic                  busy;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  wr_dgate;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] t_idx;
  logic                  first_t;
  logic                  done;

  modport master (
    input  start, stall,
    output busy, rd_en, rd_addr, wr_dgate, wr_addr, t_idx, first_t, done
  );

  modport slave (
    output start, stall,
    input  busy, rd_en, rd_addr, wr_dgate, wr_addr, t_idx, first_t, done
  );
endinterface

// File: rtl/lstm_bp_dgate_ctrl.sv
// Backprop-phase controller for one LSTM layer, producer side of the
// delta-gate RAMs. Sweeps timesteps TIMESTEP-1 down to 0 and cells
// 0..NUM_CELL-1, issuing one read per element and the matching delta-gate
// write DELAY unstalled cycles later, then pulses done.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-low reset
//   bus  : master side of lstm_bp_dgate_ctrl_if (start/stall in; busy,
//          rd_en, rd_addr, wr_dgate, wr_addr, t_idx, first_t, done out)
module lstm_bp_dgate_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int TIMESTEP   = 7,
  parameter int NUM_CELL   = 8,
  parameter int DELAY      = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  lstm_bp_dgate_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_T = ADDR_WIDTH'(TIMESTEP - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_N = ADDR_WIDTH'(NUM_CELL - 1);
  localparam logic [ADDR_WIDTH-1:0] NC     = ADDR_WIDTH'(NUM_CELL);
  localparam logic [DW-1:0]         LAST_D = DW'(DELAY - 1);

  state_t                          state_q, state_d;
  logic [ADDR_WIDTH-1:0]           t_q, t_d;
  logic [ADDR_WIDTH-1:0]           n_q, n_d;
  logic [ADDR_WIDTH-1:0]           rd_addr_q, rd_addr_d;
  logic [DW-1:0]                   drain_q, drain_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;
  logic                            first_t_q, first_t_d;

  // Read-to-write delay line: stage DELAY-1 drives the write port.
  logic                            adv;
  logic                            push_v;
  logic [ADDR_WIDTH-1:0]           push_a;
  logic [DELAY-1:0]                pipe_v_q;
  logic [DELAY-1:0][ADDR_WIDTH-1:0] pipe_a_q;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    n_d     = n_q;
    drain_d = drain_q;
    adv     = 1'b0;
    push_v  = 1'b0;
    push_a  = '0;

    case (state_q)
      IDLE: begin
        // start wins over stall here; stall only matters once sweeping.
        if (bus.start) begin
          state_d = RUN;
          t_d     = LAST_T;
          n_d     = '0;
          drain_d = '0;
        end
      end

      RUN: begin
        if (!bus.stall) begin
          adv    = 1'b1;
          push_v = 1'b1;
          push_a = rd_addr_q;
          if (n_q != LAST_N) begin
            n_d = n_q + ADDR_WIDTH'(1);
          end else begin
            n_d = '0;
            if (t_q != '0) begin
              t_d = t_q - ADDR_WIDTH'(1);
            end else begin
              state_d = DRAIN;
              drain_d = '0;
            end
          end
        end
      end

      DRAIN: begin
        // Bubbles flush the last DELAY reads out to the write port.
        if (!bus.stall) begin
          adv = 1'b1;
          if (drain_q == LAST_D) begin
            state_d = DONE;
          end else begin
            drain_d = drain_q + DW'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    rd_addr_d = t_d * NC + n_d;
    busy_d    = (state_d == RUN) || (state_d == DRAIN);
    done_d    = (state_d == DONE);
    first_t_d = (state_d == RUN) && (t_d == LAST_T);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      t_q       <= '0;
      n_q       <= '0;
      rd_addr_q <= '0;
      drain_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      first_t_q <= 1'b0;
      pipe_v_q  <= '0;
      pipe_a_q  <= '0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      n_q       <= n_d;
      rd_addr_q <= rd_addr_d;
      drain_q   <= drain_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      first_t_q <= first_t_d;
      if (adv) begin
        for (int unsigned i = DELAY - 1; i > 0; i--) begin
          pipe_v_q[i] <= pipe_v_q[i-1];
          pipe_a_q[i] <= pipe_a_q[i-1];
        end
        pipe_v_q[0] <= push_v;
        pipe_a_q[0] <= push_a;
      end
    end
  end

  // Strobes are masked by stall in the same cycle; addresses simply hold.
  assign bus.busy     = busy_q;
  assign bus.rd_en    = (state_q == RUN) && !bus.stall;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.wr_dgate = pipe_v_q[DELAY-1] && !bus.stall;
  assign bus.wr_addr  = pipe_a_q[DELAY-1];
  assign bus.t_idx    = t_q;
  assign bus.first_t  = first_t_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_lstm_bp_dgate_ctrl.sv
module tb_lstm_bp_dgate_ctrl;
  localparam int AW   = 12;
  localparam int TS   = 7;
  localparam int NC   = 8;
  localparam int NEL  = TS * NC;
  localparam int LOGN = 80;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lstm_bp_dgate_ctrl_if #(.ADDR_WIDTH(AW)) bus_a ();
  lstm_bp_dgate_ctrl_if #(.ADDR_WIDTH(AW)) bus_b ();

  lstm_bp_dgate_ctrl #(.ADDR_WIDTH(AW), .TIMESTEP(TS), .NUM_CELL(NC), .DELAY(3)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );

  // Degenerate single-timestep sweep with a one-cycle datapath.
  lstm_bp_dgate_ctrl #(.ADDR_WIDTH(AW), .TIMESTEP(1), .NUM_CELL(4), .DELAY(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  logic          lg_rden [LOGN];
  logic [AW-1:0] lg_rda  [LOGN];
  logic          lg_wr   [LOGN];
  logic [AW-1:0] lg_wra  [LOGN];
  logic          lg_done [LOGN];
  logic          lg_busy [LOGN];
  logic          lg_ft   [LOGN];
  logic [AW-1:0] lg_tidx [LOGN];

  // Expected address of the i-th element in sweep order.
  function automatic int exp_addr(input int i);
    return (TS - 1 - i / NC) * NC + i % NC;
  endfunction

  // Pulses start on dut_a and records LOGN cycles; cycle 0 is the first RUN cycle.
  task automatic run_sweep(input int st_from, input int st_len, input int s_a, input int s_b);
    @(posedge clk); #1;
    bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    for (int c = 0; c < LOGN; c++) begin
      bus_a.stall = (c >= st_from) && (c < st_from + st_len);
      bus_a.start = (c == s_a) || (c == s_b);
      #2;
      lg_rden[c] = bus_a.rd_en;
      lg_rda[c]  = bus_a.rd_addr;
      lg_wr[c]   = bus_a.wr_dgate;
      lg_wra[c]  = bus_a.wr_addr;
      lg_done[c] = bus_a.done;
      lg_busy[c] = bus_a.busy;
      lg_ft[c]   = bus_a.first_t;
      lg_tidx[c] = bus_a.t_idx;
      @(posedge clk); #1;
    end
    bus_a.start = 1'b0;
    bus_a.stall = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus_a.start = 1'b0; bus_a.stall = 1'b0;
    bus_b.start = 1'b0; bus_b.stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus_a.busy); end
    checks++; if (bus_a.rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %0b want 0", bus_a.rd_en); end
    checks++; if (bus_a.rd_addr !== 12'd0) begin errors++; $display("FAIL reset_rd_addr got %0d want 0", bus_a.rd_addr); end
    checks++; if (bus_a.wr_dgate !== 1'b0) begin errors++; $display("FAIL reset_wr_dgate got %0b want 0", bus_a.wr_dgate); end
    checks++; if (bus_a.wr_addr !== 12'd0) begin errors++; $display("FAIL reset_wr_addr got %0d want 0", bus_a.wr_addr); end
    checks++; if (bus_a.t_idx !== 12'd0) begin errors++; $display("FAIL reset_t_idx got %0d want 0", bus_a.t_idx); end
    checks++; if (bus_a.first_t !== 1'b0) begin errors++; $display("FAIL reset_first_t got %0b want 0", bus_a.first_t); end
    checks++; if (bus_a.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", bus_a.done); end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %0b want 0", bus_a.busy); end
  endtask

  task automatic test_sweep();
    int nrd, nwr, ndone, first_rd, first_wr, last_wr, done_c;
    run_sweep(-1, 0, -1, -1);
    nrd = 0; nwr = 0; ndone = 0; first_rd = -1; first_wr = -1; last_wr = -1; done_c = -1;
    for (int c = 0; c < LOGN; c++) begin
      if (lg_rden[c]) begin
        if (first_rd < 0) first_rd = c;
        checks++;
        if (nrd >= NEL || lg_rda[c] !== AW'(exp_addr(nrd))) begin
          errors++; $display("FAIL sweep_rd_addr[%0d] got %0d want %0d", nrd, lg_rda[c], exp_addr(nrd));
        end
        nrd++;
      end
      if (lg_wr[c]) begin
        if (first_wr < 0) first_wr = c;
        last_wr = c;
        checks++;
        if (nwr >= NEL || lg_wra[c] !== AW'(exp_addr(nwr))) begin
          errors++; $display("FAIL sweep_wr_addr[%0d] got %0d want %0d", nwr, lg_wra[c], exp_addr(nwr));
        end
        nwr++;
      end
      if (lg_done[c]) begin ndone++; done_c = c; end
    end
    checks++; if (nrd != 56) begin errors++; $display("FAIL sweep_reads got %0d want 56", nrd); end
    checks++; if (nwr != 56) begin errors++; $display("FAIL sweep_writes got %0d want 56", nwr); end
    checks++; if (first_rd != 0) begin errors++; $display("FAIL sweep_first_rd got %0d want 0", first_rd); end
    checks++; if (first_wr != 3) begin errors++; $display("FAIL sweep_first_wr got %0d want 3", first_wr); end
    checks++; if (last_wr != 58) begin errors++; $display("FAIL sweep_last_wr got %0d want 58", last_wr); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL sweep_done_count got %0d want 1", ndone); end
    checks++; if (done_c != 59) begin errors++; $display("FAIL sweep_done_cycle got %0d want 59", done_c); end
    checks++; if (lg_busy[0] !== 1'b1) begin errors++; $display("FAIL sweep_busy_run got %0b want 1", lg_busy[0]); end
    checks++; if (lg_busy[58] !== 1'b1) begin errors++; $display("FAIL sweep_busy_drain got %0b want 1", lg_busy[58]); end
    checks++; if (lg_busy[60] !== 1'b0) begin errors++; $display("FAIL sweep_busy_after got %0b want 0", lg_busy[60]); end
  endtask

  task automatic test_stall();
    int nrd, nwr, ndone, done_c;
    run_sweep(10, 4, -1, -1);
    for (int c = 10; c < 14; c++) begin
      checks++; if (lg_rden[c] !== 1'b0) begin errors++; $display("FAIL stall_rd_en@%0d got %0b want 0", c, lg_rden[c]); end
      checks++; if (lg_wr[c] !== 1'b0) begin errors++; $display("FAIL stall_wr_dgate@%0d got %0b want 0", c, lg_wr[c]); end
      checks++; if (lg_rda[c] !== 12'd42) begin errors++; $display("FAIL stall_rd_addr@%0d got %0d want 42", c, lg_rda[c]); end
      checks++; if (lg_wra[c] !== 12'd55) begin errors++; $display("FAIL stall_wr_addr@%0d got %0d want 55", c, lg_wra[c]); end
    end
    checks++; if (lg_rden[14] !== 1'b1 || lg_rda[14] !== 12'd42) begin
      errors++; $display("FAIL stall_resume got en=%0b addr=%0d want en=1 addr=42", lg_rden[14], lg_rda[14]);
    end
    nrd = 0; nwr = 0; ndone = 0; done_c = -1;
    for (int c = 0; c < LOGN; c++) begin
      if (lg_rden[c]) begin
        checks++;
        if (nrd >= NEL || lg_rda[c] !== AW'(exp_addr(nrd))) begin
          errors++; $display("FAIL stall_rd_seq[%0d] got %0d want %0d", nrd, lg_rda[c], exp_addr(nrd));
        end
        nrd++;
      end
      if (lg_wr[c]) begin
        checks++;
        if (nwr >= NEL || lg_wra[c] !== AW'(exp_addr(nwr))) begin
          errors++; $display("FAIL stall_wr_seq[%0d] got %0d want %0d", nwr, lg_wra[c], exp_addr(nwr));
        end
        nwr++;
      end
      if (lg_done[c]) begin ndone++; done_c = c; end
    end
    checks++; if (nwr != 56) begin errors++; $display("FAIL stall_writes got %0d want 56", nwr); end
    checks++; if (ndone != 1 || done_c != 63) begin
      errors++; $display("FAIL stall_done got count=%0d cycle=%0d want count=1 cycle=63", ndone, done_c);
    end
  endtask

  task automatic test_restart_ignored();
    int nwr, ndone, done_c;
    run_sweep(-1, 0, 10, 59);
    nwr = 0; ndone = 0; done_c = -1;
    for (int c = 0; c < LOGN; c++) begin
      if (lg_wr[c]) nwr++;
      if (lg_done[c]) begin ndone++; done_c = c; end
    end
    checks++; if (nwr != 56) begin errors++; $display("FAIL restart_writes got %0d want 56", nwr); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL restart_done_count got %0d want 1", ndone); end
    checks++; if (done_c != 59) begin errors++; $display("FAIL restart_done_cycle got %0d want 59", done_c); end
    checks++; if (lg_busy[62] !== 1'b0) begin errors++; $display("FAIL restart_not_queued busy got %0b want 0", lg_busy[62]); end
  endtask

  task automatic test_reset_mid();
    int bad;
    @(posedge clk); #1;
    bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
    end
    #2;
    checks++; if (bus_a.rd_en !== 1'b1 || bus_a.rd_addr !== 12'd30) begin
      errors++; $display("FAIL midrst_pre got en=%0b addr=%0d want en=1 addr=30", bus_a.rd_en, bus_a.rd_addr);
    end
    rst = 1'b0;
    #1;
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %0b want 0", bus_a.busy); end
    checks++; if (bus_a.rd_en !== 1'b0) begin errors++; $display("FAIL midrst_rd_en got %0b want 0", bus_a.rd_en); end
    checks++; if (bus_a.rd_addr !== 12'd0) begin errors++; $display("FAIL midrst_rd_addr got %0d want 0", bus_a.rd_addr); end
    checks++; if (bus_a.wr_dgate !== 1'b0) begin errors++; $display("FAIL midrst_wr_dgate got %0b want 0", bus_a.wr_dgate); end
    checks++; if (bus_a.wr_addr !== 12'd0) begin errors++; $display("FAIL midrst_wr_addr got %0d want 0", bus_a.wr_addr); end
    checks++; if (bus_a.t_idx !== 12'd0) begin errors++; $display("FAIL midrst_t_idx got %0d want 0", bus_a.t_idx); end
    checks++; if (bus_a.first_t !== 1'b0) begin errors++; $display("FAIL midrst_first_t got %0b want 0", bus_a.first_t); end
    checks++; if (bus_a.done !== 1'b0) begin errors++; $display("FAIL midrst_done got %0b want 0", bus_a.done); end
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #3;
      if (bus_a.wr_dgate !== 1'b0 || bus_a.busy !== 1'b0) bad++;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #3;
      if (bus_a.wr_dgate !== 1'b0 || bus_a.busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL midrst_quiet got %0d active cycles want 0", bad); end
    run_sweep(-1, 0, -1, -1);
    checks++; if (lg_rden[0] !== 1'b1 || lg_rda[0] !== 12'd48) begin
      errors++; $display("FAIL midrst_restart got en=%0b addr=%0d want en=1 addr=48", lg_rden[0], lg_rda[0]);
    end
    checks++; if (lg_done[59] !== 1'b1) begin errors++; $display("FAIL midrst_done got %0b want 1", lg_done[59]); end
  endtask

  task automatic test_first_t();
    int t_exp;
    run_sweep(-1, 0, -1, -1);
    for (int c = 0; c < NEL; c++) begin
      t_exp = TS - 1 - c / NC;
      checks++; if (lg_ft[c] !== (c < NC)) begin errors++; $display("FAIL first_t@%0d got %0b want %0b", c, lg_ft[c], (c < NC)); end
      checks++; if (lg_tidx[c] !== AW'(t_exp)) begin errors++; $display("FAIL t_idx@%0d got %0d want %0d", c, lg_tidx[c], t_exp); end
    end
    checks++; if (lg_ft[NEL] !== 1'b0) begin errors++; $display("FAIL first_t_drain got %0b want 0", lg_ft[NEL]); end
  endtask

  // TIMESTEP=1, NUM_CELL=4, DELAY=1: reads 0..3 at cycles 0..3, writes at 1..4, done at 5.
  task automatic test_delay1();
    logic rd_en_o, wr_o, done_o, ft_o;
    logic [AW-1:0] rda_o, wra_o;
    @(posedge clk); #1;
    bus_b.start = 1'b1;
    @(posedge clk); #1;
    bus_b.start = 1'b0;
    for (int c = 0; c < 9; c++) begin
      #2;
      rd_en_o = bus_b.rd_en; rda_o = bus_b.rd_addr;
      wr_o = bus_b.wr_dgate; wra_o = bus_b.wr_addr;
      done_o = bus_b.done; ft_o = bus_b.first_t;
      checks++; if (rd_en_o !== (c < 4) || (c < 4 && rda_o !== AW'(c))) begin
        errors++; $display("FAIL d1_read@%0d got en=%0b addr=%0d want en=%0b addr=%0d", c, rd_en_o, rda_o, (c < 4), c);
      end
      checks++; if (wr_o !== (c >= 1 && c <= 4) || (c >= 1 && c <= 4 && wra_o !== AW'(c - 1))) begin
        errors++; $display("FAIL d1_write@%0d got en=%0b addr=%0d want en=%0b addr=%0d", c, wr_o, wra_o, (c >= 1 && c <= 4), c - 1);
      end
      checks++; if (done_o !== (c == 5)) begin errors++; $display("FAIL d1_done@%0d got %0b want %0b", c, done_o, (c == 5)); end
      checks++; if (ft_o !== (c < 4)) begin errors++; $display("FAIL d1_first_t@%0d got %0b want %0b", c, ft_o, (c < 4)); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_stall();
    test_restart_ignored();
    test_reset_mid();
    test_first_t();
    test_delay1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
